// File: rtl/gpio_in_capture.sv
// GPIO header input capture: 2-flop synchronizer, per-byte-lane debounce, sticky rise flags, change counter.
// Optional feature macro: GPIO_IN_DEBOUNCE_EN (undefined: lanes follow the synchronizer directly).
module gpio_in_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [31:0] GPIO,
  input  logic [1:0]  sel,
  input  logic        clear,
  output logic [7:0]  data_out,
  output logic [7:0]  rise_out,
  output logic [31:0] gpio_all,
  output logic        changed,
  output logic [15:0] event_count
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'd1048575) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..2^20-1");
  end

  logic [31:0] sync1, sync2;
  logic [31:0] deb, deb_next;
  logic [31:0] flags;
  logic [3:0]  lane_upd;
  logic        any_upd;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [7:0]  cand [4];
  logic [19:0] cnt  [4];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned l = 0; l < 4; l++) begin
        cand[l] <= '0;
        cnt[l]  <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (sync2[8*l +: 8] != cand[l]) begin
          cand[l] <= sync2[8*l +: 8];
          cnt[l]  <= '0;
        end else if (cand[l] != deb[8*l +: 8]) begin
          if (cnt[l] == CNT_LAST) cnt[l] <= '0;
          else                    cnt[l] <= cnt[l] + 20'd1;
        end
      end
    end
  end

  // A lane commits only when its candidate is still being confirmed by sync2 this cycle.
  always_comb begin
    lane_upd = '0;
    deb_next = deb;
    for (int unsigned l = 0; l < 4; l++) begin
      if (sync2[8*l +: 8] == cand[l] && cand[l] != deb[8*l +: 8] && cnt[l] == CNT_LAST) begin
        lane_upd[l]         = 1'b1;
        deb_next[8*l +: 8]  = cand[l];
      end
    end
  end
`else
  always_comb begin
    lane_upd = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      if (sync2[8*l +: 8] != deb[8*l +: 8]) lane_upd[l] = 1'b1;
    end
    deb_next = sync2;
  end
`endif

  assign any_upd = |lane_upd;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      deb         <= '0;
      flags       <= '0;
      changed     <= 1'b0;
      event_count <= '0;
    end else begin
      sync1   <= GPIO;
      sync2   <= sync1;
      deb     <= deb_next;
      // Set is OR-ed after the clear so a coincident rise survives.
      flags   <= (clear ? '0 : flags) | (deb_next & ~deb);
      changed <= any_upd;
      if (clear)
        event_count <= {15'd0, any_upd};
      else if (any_upd && event_count != '1)
        event_count <= event_count + 16'd1;
    end
  end

  always_comb begin
    data_out = deb[7:0];
    rise_out = flags[7:0];
    case (sel)
      2'd0: begin data_out = deb[7:0];   rise_out = flags[7:0];   end
      2'd1: begin data_out = deb[15:8];  rise_out = flags[15:8];  end
      2'd2: begin data_out = deb[23:16]; rise_out = flags[23:16]; end
      2'd3: begin data_out = deb[31:24]; rise_out = flags[31:24]; end
      default: ;
    endcase
  end

  assign gpio_all = deb;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed bench for gpio_in_capture; expected lane words are queued at drive time and checked on each changed pulse.
`timescale 1ns/1ps
module tb_gpio_in_capture;

  localparam int unsigned D = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned LAT = D + 3;
`else
  localparam int unsigned LAT = 3;
`endif

  logic        CLOCK_50;
  logic        reset;
  logic [31:0] GPIO;
  logic [1:0]  sel;
  logic        clear;
  logic [7:0]  data_out;
  logic [7:0]  rise_out;
  logic [31:0] gpio_all;
  logic        changed;
  logic [15:0] event_count;

  gpio_in_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .GPIO        (GPIO),
    .sel         (sel),
    .clear       (clear),
    .data_out    (data_out),
    .rise_out    (rise_out),
    .gpio_all    (gpio_all),
    .changed     (changed),
    .event_count (event_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] all;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned drive_cyc   = 0;
  int unsigned exp_cnt     = 0;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] v);
    GPIO      = v;
    drive_cyc = cyc;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] all);
    exp_t e;
    e.tag = tag;
    e.all = all;
    e.lat = LAT;
    sb.push_back(e);
  endtask

  task automatic wait_update();
    exp_t e;
    bit   seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLOCK_50);
      if (changed === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    vectors++;
    assert (seen) else begin
      miscompares++;
      $error("FAIL %s_timeout: changed observed 0 expected 1", e.tag);
    end
    if (seen) begin
      chk32({e.tag, "_word"}, gpio_all, e.all);
      chk32({e.tag, "_latency"}, cyc - drive_cyc, e.lat);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_data"},  {24'd0, data_out}, 32'd0);
    chk32({tag, "_rise"},  {24'd0, rise_out}, 32'd0);
    chk32({tag, "_all"},   gpio_all, 32'd0);
    chk32({tag, "_chg"},   {31'd0, changed}, 32'd0);
    chk32({tag, "_count"}, {16'd0, event_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    GPIO  = '1;
    sel   = 2'd0;
    clear = 1'b0;

    // reset with all pins high
    repeat (3) begin
      @(negedge CLOCK_50);
      chk_all_zero("in_reset");
    end
    reset = 1'b0;
    GPIO  = '0;
    @(negedge CLOCK_50);
    chk_all_zero("post_reset");
    repeat (3) @(negedge CLOCK_50);

    // basic lane 0
    drive(32'h0000_00A5);
    expect_word("lane0", 32'h0000_00A5);
    exp_cnt++;
    wait_update();
    chk32("lane0_data", {24'd0, data_out}, 32'hA5);
    chk32("lane0_rise", {24'd0, rise_out}, 32'hA5);
    chk32("lane0_count", {16'd0, event_count}, exp_cnt);
    @(negedge CLOCK_50);
    chk32("lane0_pulse_end", {31'd0, changed}, 32'd0);

    // three-sample glitch on lane 1
`ifdef GPIO_IN_DEBOUNCE_EN
    drive(32'h0000_FFA5);
    repeat (3) @(negedge CLOCK_50);
    drive(32'h0000_00A5);
    repeat (15) begin
      @(negedge CLOCK_50);
      chk32("glitch_chg", {31'd0, changed}, 32'd0);
      chk32("glitch_lane1", {24'd0, gpio_all[15:8]}, 32'd0);
    end
`else
    drive(32'h0000_FFA5);
    expect_word("glitch_up", 32'h0000_FFA5);
    exp_cnt++;
    wait_update();
    drive(32'h0000_00A5);
    expect_word("glitch_down", 32'h0000_00A5);
    exp_cnt++;
    wait_update();
    repeat (3) @(negedge CLOCK_50);
`endif
    chk32("glitch_count", {16'd0, event_count}, exp_cnt);

    // lanes 0 and 3 change on the same edge
    drive(32'h0F00_000F);
    expect_word("dual", 32'h0F00_000F);
    exp_cnt++;
    wait_update();
    chk32("dual_count", {16'd0, event_count}, exp_cnt);
    sel = 2'd3;
    #1;
    chk32("dual_lane3_data", {24'd0, data_out}, 32'h0F);
    chk32("dual_lane3_rise", {24'd0, rise_out}, 32'h0F);
    sel = 2'd0;
    #1;
    chk32("dual_lane0_rise", {24'd0, rise_out}, 32'hAF);
    @(negedge CLOCK_50);
    chk32("dual_pulse_end", {31'd0, changed}, 32'd0);

    // clear lands on the edge where bit 16 rises
    drive(32'h0F01_000F);
    expect_word("collide", 32'h0F01_000F);
    repeat (LAT - 1) @(negedge CLOCK_50);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      chk32("collide_chg", {31'd0, changed}, 32'd1);
      chk32("collide_word", gpio_all, e.all);
    end
    exp_cnt = 1;
    chk32("collide_count", {16'd0, event_count}, exp_cnt);
    sel = 2'd0;
    #1;
    chk32("collide_lane0_rise", {24'd0, rise_out}, 32'h00);
    sel = 2'd2;
    #1;
    chk32("collide_lane2_rise", {24'd0, rise_out}, 32'h01);
    sel = 2'd3;
    #1;
    chk32("collide_lane3_rise", {24'd0, rise_out}, 32'h00);

    // clear with no update
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    exp_cnt = 0;
    chk32("clear_count", {16'd0, event_count}, exp_cnt);
    sel = 2'd2;
    #1;
    chk32("clear_lane2_rise", {24'd0, rise_out}, 32'h00);

`ifndef GPIO_IN_DEBOUNCE_EN
    // every toggle of bit 0 is one update cycle
    for (int i = 0; i < 65000; i++) begin
      @(negedge CLOCK_50);
      GPIO[0] = ~GPIO[0];
    end
    repeat (5) @(negedge CLOCK_50);
    chk32("count_65000", {16'd0, event_count}, 32'd65000);
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLOCK_50);
      GPIO[0] = ~GPIO[0];
    end
    repeat (5) @(negedge CLOCK_50);
    chk32("count_saturated", {16'd0, event_count}, 32'h0000_FFFF);
    chk32("sat_idle_chg", {31'd0, changed}, 32'd0);
`endif

    // reset two cycles into a pending change
    @(negedge CLOCK_50);
    drive(32'h1234_5678);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2) begin
      @(negedge CLOCK_50);
      chk32("midrst_all", gpio_all, 32'd0);
      chk32("midrst_chg", {31'd0, changed}, 32'd0);
      chk32("midrst_count", {16'd0, event_count}, 32'd0);
    end
    reset     = 1'b0;
    drive_cyc = cyc;
    expect_word("redebounce", 32'h1234_5678);
    wait_update();
    chk32("redebounce_count", {16'd0, event_count}, 32'd1);
    sel = 2'd0;
    #1;
    chk32("redebounce_lane0_rise", {24'd0, rise_out}, 32'h78);
    sel = 2'd3;
    #1;
    chk32("redebounce_lane3_data", {24'd0, data_out}, 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
